// File: rtl/timer_pkg.sv
// timer_pkg: constants shared by the interval timer and the logic that drives it.
//   MODE_ONESHOT / MODE_PERIODIC : encodings of the 'periodic' mode input.
//   CLK_HZ                       : board clock rate, for callers that convert seconds into a limit.
package timer_pkg;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;
  localparam int   CLK_HZ        = 50_000_000;

endpackage

// File: rtl/clk_prescaler.sv
// clk_prescaler: divides clk into a one-cycle count strobe every PRESCALE cycles.
// Ports:
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   clear  in  synchronous restart of the division (counter back to 0)
//   hold   in  freeze the counter and suppress the strobe
//   strobe out high on the cycle the counter sits at PRESCALE-1 and hold is low
// With PRESCALE=1 there is no counter; the strobe is simply ~hold.
module clk_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic hold,
  output logic strobe
);

  generate
    if (PRESCALE <= 1) begin : g_bypass
      // Clock, reset and clear have no state to act on in this configuration.
      logic w_unused;
      assign w_unused = clk ^ rst_n ^ clear;
      assign strobe   = ~hold;
    end else begin : g_count
      localparam int             CW   = $clog2(PRESCALE);
      localparam logic [CW-1:0]  LAST = CW'(PRESCALE - 1);

      logic [CW-1:0] r_cnt;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt <= '0;
        end else if (clear) begin
          r_cnt <= '0;
        end else if (!hold) begin
          r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
        end
      end

      assign strobe = ~hold & (r_cnt == LAST);
    end
  endgenerate

endmodule

// File: rtl/interval_timer.sv
// interval_timer: counts prescaled strobes from 0 up to a latched limit, then either
// raises a sticky done (one-shot) or pulses tick and restarts (periodic).
// Ports:
//   clk      in  system clock, all logic on posedge
//   rst_n    in  asynchronous active-low reset
//   enable   in  level; rising level arms, low clears everything on the next edge
//   periodic in  mode, latched at arm (MODE_ONESHOT / MODE_PERIODIC)
//   pause    in  level; holds count and prescaler
//   limit    in  terminal count, latched at arm
//   count    out current count
//   tick     out registered one-cycle pulse on each terminal event
//   done     out one-shot only: sticky after terminal until enable drops
//   running  out armed and not yet done
module interval_timer
  import timer_pkg::*;
#(
  parameter int WIDTH    = 26,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             periodic,
  input  logic             pause,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             done,
  output logic             running
);

  logic             r_enable_q;
  logic             r_mode;
  logic [WIDTH-1:0] r_limit;
  logic [WIDTH-1:0] r_count;
  logic             r_tick;
  logic             r_done;
  logic             r_running;

  logic w_arm;
  logic w_clear;
  logic w_hold;
  logic w_strobe;
  logic w_step;
  logic w_terminal;

  // Arming is the first enabled edge after enable was low (r_enable_q resets to 0,
  // so enable already high at reset release arms on the first edge).
  assign w_arm      = enable & ~r_enable_q;
  assign w_clear    = ~enable | w_arm;
  // The prescaler only advances while actually counting.
  assign w_hold     = pause | ~r_running;
  assign w_step     = w_strobe & r_running & ~pause;
  assign w_terminal = (r_count == r_limit);

  clk_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (w_clear),
    .hold   (w_hold),
    .strobe (w_strobe)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_enable_q <= 1'b0;
      r_mode     <= MODE_ONESHOT;
      r_limit    <= '0;
      r_count    <= '0;
      r_tick     <= 1'b0;
      r_done     <= 1'b0;
      r_running  <= 1'b0;
    end else begin
      r_enable_q <= enable;
      if (!enable) begin
        // Dropping enable wins over a terminal event on the same edge.
        r_count   <= '0;
        r_tick    <= 1'b0;
        r_done    <= 1'b0;
        r_running <= 1'b0;
      end else if (w_arm) begin
        r_limit   <= limit;
        r_mode    <= periodic;
        r_count   <= '0;
        r_tick    <= 1'b0;
        r_done    <= 1'b0;
        r_running <= 1'b1;
      end else begin
        r_tick <= 1'b0;
        if (w_step) begin
          if (w_terminal) begin
            r_tick <= 1'b1;
            if (r_mode == MODE_PERIODIC) begin
              r_count <= '0;
            end else begin
              // One-shot: count parks at the limit, so an all-ones limit never wraps.
              r_done    <= 1'b1;
              r_running <= 1'b0;
            end
          end else begin
            r_count <= r_count + WIDTH'(1);
          end
        end
      end
    end
  end

  assign count   = r_count;
  assign tick    = r_tick;
  assign done    = r_done;
  assign running = r_running;

endmodule

// File: tb/tb_interval_timer.sv
// Bench for interval_timer: two instances (PRESCALE=1 and PRESCALE=4, WIDTH=8) share
// stimulus. An elapsed-time model predicts every output each cycle; directed checks
// pin the scenario timings by hand.
module tb_interval_timer;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         enable;
  logic         periodic;
  logic         pause;
  logic [W-1:0] limit;

  logic [W-1:0] cnt1, cnt4;
  logic         tick1, tick4, done1, done4, run1, run4;

  int n_checks = 0;
  int n_err    = 0;
  logic chk_en = 1'b0;

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  interval_timer #(.WIDTH(W), .PRESCALE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .periodic(periodic), .pause(pause),
    .limit(limit), .count(cnt1), .tick(tick1), .done(done1), .running(run1)
  );

  interval_timer #(.WIDTH(W), .PRESCALE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .periodic(periodic), .pause(pause),
    .limit(limit), .count(cnt4), .tick(tick4), .done(done4), .running(run4)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: counts active (enabled, armed, unpaused) cycles since arm and derives
  // count/tick/done from elapsed time, the limit and the prescale ratio.
  int   ps    [2] = '{1, 4};
  int   m_act [2];
  int   m_lim [2];
  logic m_mode[2];
  logic m_run [2];
  logic m_tick[2];
  logic m_pen;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_act[i] = 0; m_lim[i] = 0; m_mode[i] = 1'b0; m_run[i] = 1'b0; m_tick[i] = 1'b0;
      end
      m_pen = 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_tick[i] = 1'b0;
        if (!enable) begin
          m_act[i] = 0;
          m_run[i] = 1'b0;
        end else if (!m_pen) begin
          m_lim[i]  = int'(limit);
          m_mode[i] = periodic;
          m_act[i]  = 0;
          m_run[i]  = 1'b1;
        end else if (m_run[i] && !pause) begin
          m_act[i]++;
          if (m_act[i] % ((m_lim[i] + 1) * ps[i]) == 0) begin
            m_tick[i] = 1'b1;
            if (!m_mode[i]) m_run[i] = 1'b0;
          end
        end
      end
      m_pen = enable;
    end
  end

  function automatic int exp_count(input int i);
    int n;
    n = m_act[i] / ps[i];
    if (m_mode[i]) return n % (m_lim[i] + 1);
    return (n > m_lim[i]) ? m_lim[i] : n;
  endfunction

  function automatic int exp_done(input int i);
    return (!m_mode[i] && m_act[i] >= (m_lim[i] + 1) * ps[i]) ? 1 : 0;
  endfunction

  // compare process, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("p1_count",   int'(cnt1),  exp_count(0));
      chk("p1_tick",    int'(tick1), int'(m_tick[0]));
      chk("p1_done",    int'(done1), exp_done(0));
      chk("p1_running", int'(run1),  int'(m_run[0]));
      chk("p4_count",   int'(cnt4),  exp_count(1));
      chk("p4_tick",    int'(tick4), int'(m_tick[1]));
      chk("p4_done",    int'(done4), exp_done(1));
      chk("p4_running", int'(run4),  int'(m_run[1]));
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic arm(input logic per, input logic [W-1:0] lim);
    periodic = per;
    limit    = lim;
    enable   = 1'b1;
    step(1);
  endtask

  task automatic disarm();
    enable = 1'b0;
    step(1);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; periodic = 1'b0; pause = 1'b0; limit = '0;
    step(3);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    chk("reset_count", int'(cnt1), 0);
    chk("reset_done",  int'(done1), 0);
    chk("reset_run",   int'(run1), 0);
    step(1);

    // one-shot, limit 5: tick 6 cycles after arm
    arm(1'b0, 8'd5);
    chk("os5_arm_run",   int'(run1), 1);
    chk("os5_arm_count", int'(cnt1), 0);
    step(5);
    chk("os5_k5_count", int'(cnt1), 5);
    chk("os5_k5_tick",  int'(tick1), 0);
    step(1);
    chk("os5_k6_tick",  int'(tick1), 1);
    chk("os5_k6_done",  int'(done1), 1);
    chk("os5_k6_count", int'(cnt1), 5);
    chk("os5_k6_run",   int'(run1), 0);
    step(1);
    chk("os5_k7_tick",  int'(tick1), 0);
    chk("os5_k7_done",  int'(done1), 1);
    disarm();
    chk("os5_off_done",  int'(done1), 0);
    chk("os5_off_count", int'(cnt1), 0);

    // periodic, limit 3, prescale 4: tick every 16 cycles
    arm(1'b1, 8'd3);
    step(4);
    chk("per3_p4_k4_count", int'(cnt4), 1);
    step(11);
    chk("per3_p4_k15_count", int'(cnt4), 3);
    chk("per3_p4_k15_tick",  int'(tick4), 0);
    step(1);
    chk("per3_p4_k16_tick",  int'(tick4), 1);
    chk("per3_p4_k16_count", int'(cnt4), 0);
    step(16);
    chk("per3_p4_k32_tick",  int'(tick4), 1);
    chk("per3_p4_k32_done",  int'(done4), 0);
    disarm();

    // periodic, limit 0: tick every cycle
    arm(1'b1, 8'd0);
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("per0_tick", int'(tick1), 1);
    end
    disarm();

    // one-shot, limit 255: done after 256 cycles, no wrap
    arm(1'b0, 8'd255);
    step(255);
    chk("os255_k255_count", int'(cnt1), 255);
    chk("os255_k255_done",  int'(done1), 0);
    step(1);
    chk("os255_k256_tick", int'(tick1), 1);
    chk("os255_k256_done", int'(done1), 1);
    step(1);
    chk("os255_k257_count", int'(cnt1), 255);
    chk("os255_k257_tick",  int'(tick1), 0);
    disarm();

    // pause 10 cycles at count 2 delays tick by 10
    arm(1'b0, 8'd5);
    step(2);
    chk("pause_pre_count", int'(cnt1), 2);
    pause = 1'b1;
    step(10);
    chk("pause_hold_count", int'(cnt1), 2);
    pause = 1'b0;
    step(3);
    chk("pause_k15_tick", int'(tick1), 0);
    step(1);
    chk("pause_k16_tick", int'(tick1), 1);
    disarm();

    // enable low on the terminal edge, then re-arm; limit change mid-run ignored
    arm(1'b0, 8'd2);
    step(2);
    enable = 1'b0;
    step(1);
    chk("kill_tick",  int'(tick1), 0);
    chk("kill_done",  int'(done1), 0);
    chk("kill_count", int'(cnt1), 0);
    arm(1'b0, 8'd2);
    step(1);
    limit = 8'd7;
    step(2);
    chk("rearm_tick",  int'(tick1), 1);
    chk("rearm_count", int'(cnt1), 2);
    disarm();

    // asynchronous reset mid-count, enable held high through release
    arm(1'b0, 8'd100);
    step(5);
    chk("rst_pre_count", int'(cnt1), 5);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_count", int'(cnt1), 0);
    chk("rst_async_run",   int'(run1), 0);
    chk("rst_async_cnt4",  int'(cnt4), 0);
    #2 rst_n = 1'b1;
    step(1);
    chk("rst_rearm_run",   int'(run1), 1);
    chk("rst_rearm_count", int'(cnt1), 0);
    step(1);
    chk("rst_rearm_k1_count", int'(cnt1), 1);
    disarm();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
